ram_arbiter: RTL
================

# ram_arbiter

Two-requester controller for the single-port register-file RAM with bidirectional data bus, chip select (CS), output enable (OE) and write strobe (WS). The block grants the RAM to one requester at a time using round-robin arbitration. It sequences each read or write through fixed setup, strobe and done phases, and owns all RAM control pins and the shared data bus. It sits between two bus masters (for example a ROM-to-RAM loader and a CPU-side port) and the RAM instance.

## Interface
Parameters:
- DATA_SIZE, 8: data width in bits.
- ADDR_SIZE, 5: address width (32 words).

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ0, REQ1  in  1  transaction request, held high until the matching ACK.
- WE0, WE1  in  1  1 = write, 0 = read; stable while REQ is high.
- ADDR0, ADDR1  in  ADDR_SIZE  word address; stable while REQ is high.
- WDATA0, WDATA1  in  DATA_SIZE  write data; stable while REQ is high.
- GNT0, GNT1  out  1  port owns the RAM (SETUP through DONE).
- ACK0, ACK1  out  1  one-cycle completion pulse.
- RDATA  out  DATA_SIZE  last read result.
- RAM_ADDR  out  ADDR_SIZE  RAM address.
- RAM_DATA  inout  DATA_SIZE  RAM data bus.
- RAM_CS  out  1  chip select, active-low.
- RAM_OE  out  1  active-high; RAM drives the bus.
- RAM_WS  out  1  write strobe, active-low.

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any REQ high: go to SETUP.
  - At the same edge, latch the winner's WE/ADDR/WDATA and update the last-grant pointer.
- Round robin:
  - One requester: that port wins.
  - Both requesters: the port not granted last wins.
  - After reset the pointer = 1, so port 0 wins the first tie.
- SETUP: go to STROBE.
- STROBE: go to DONE.
- DONE: go to IDLE.
- Requests are sampled only in IDLE. A REQ still high in the DONE cycle, or raised again afterwards, starts a new transaction from IDLE.
- Pin behaviour, read:
  - RAM_CS = 0 in SETUP, STROBE and DONE.
  - RAM_OE = 1 in SETUP and STROBE.
  - RAM_WS = 1 throughout.
  - RAM_DATA is high-Z.
  - RDATA is registered from RAM_DATA at the edge ending STROBE.
- Pin behaviour, write:
  - RAM_CS = 0 in SETUP, STROBE and DONE.
  - RAM_OE = 0 throughout.
  - The block drives RAM_DATA = latched WDATA in SETUP, STROBE and DONE.
  - RAM_WS = 0 in STROBE only, giving data setup and hold of one cycle each.
- In IDLE: RAM_CS = 1, RAM_OE = 0, RAM_WS = 1, RAM_DATA high-Z.
- RAM_ADDR = latched address from SETUP through DONE; it holds its last value in IDLE.
- GNTn = 1 in SETUP, STROBE and DONE for the owning port.
- ACKn = 1 in DONE only.
- RDATA holds until the next read completes; writes do not change it.
- The block never drives RAM_DATA while RAM_OE = 1, including across the read/write turnaround.

## Timing
- Request seen high at edge E: SETUP in cycle E+1, STROBE in E+2, DONE/ACK in E+3, IDLE in E+4.
- Fixed latency of 3 cycles from the sampling edge to ACK. Peak throughput is one transaction per 4 cycles.
- RDATA is valid in the ACK cycle.
- Reset values:
  - State = IDLE, pointer = 1.
  - GNT0 = GNT1 = 0, ACK0 = ACK1 = 0, RDATA = 0.
  - RAM_CS = 1, RAM_OE = 0, RAM_WS = 1, RAM_ADDR = 0, RAM_DATA high-Z.
- Reset in any state: IDLE at the next edge. No ACK is issued and the write strobe is aborted. The requester re-issues.
- Requests arriving while not in IDLE wait; no request is dropped while REQ is held.

## Structure
- Package ram_arb_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, DONE);
  - default DATA_SIZE/ADDR_SIZE constants;
  - the CS/WS active-low level constants.
- Sub-module rr_arbiter2: inputs req[1:0], last pointer, and an update enable; output one-hot grant.
- The top level holds the FSM, request latches, the tri-state driver and RDATA.

## Test plan
- Port 0 write (ADDR0=5'h04, WDATA0=8'hA5): RAM_WS low exactly in cycle E+2, ACK0 at E+3. A port 1 read of 5'h04 then returns RDATA=8'hA5 with ACK1.
- REQ0 and REQ1 both high from reset: grant order 0,1,0,1 over four transactions, each ACK 4 cycles apart.
- REQ1 alone with back-to-back reads of 5'h1C and 5'h1D: consecutive grants to port 1. RAM_DATA is never driven by the block.
- Write then read, alternating ports: no cycle with RAM_OE=1 while the block drives RAM_DATA (bus-contention assertion).
- RST asserted during STROBE of a write to 5'h10: RAM_WS returns to 1 and RAM_CS to 1 next edge, no ACK, outputs match reset values.
- Read of 5'h1F (top address) after a write of 8'hFF: RDATA=8'hFF. A following write leaves RDATA unchanged.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-port RAM arbiter:
//   - state_t        : transaction sequencer states
//   - DEF_DATA_SIZE  : default data bus width
//   - DEF_ADDR_SIZE  : default address width
//   - CS_*/WS_*      : active-low chip-select / write-strobe levels
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ADDR_SIZE = 5;

  // RAM control pins are active-low
  localparam logic CS_ON  = 1'b0;
  localparam logic CS_OFF = 1'b1;
  localparam logic WS_ON  = 1'b0;
  localparam logic WS_OFF = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant logic (purely combinational).
//   req    in  2  request vector, bit n = port n
//   last   in  1  index of the port granted most recently
//   update in  1  grant enable; grant is forced to zero when low
//   gnt    out 2  one-hot grant (or zero when nothing is granted)
// On a tie the port that was not granted last wins.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       update,
  output logic [1:0] gnt
);

  // Pick a winner among the active requests
  always_comb begin
    gnt = 2'b00;
    if (update) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Grants a single-port RAM to one of two requesters (round robin) and
// sequences each access through SETUP, STROBE and DONE.
//   CLK, RST              clock, synchronous active-high reset
//   REQn/WEn/ADDRn/WDATAn requester n transaction (held until ACKn)
//   GNTn                  port n owns the RAM (SETUP..DONE)
//   ACKn                  one-cycle completion pulse (DONE)
//   RDATA                 last read result
//   RAM_ADDR/RAM_DATA     RAM address and bidirectional data bus
//   RAM_CS/RAM_WS         active-low chip select / write strobe
//   RAM_OE                active-high output enable (RAM drives bus)
// All outputs are registered; the next-cycle pin values are computed at the
// same edge that moves the state machine.
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic                 WE0,
  input  logic                 WE1,
  input  logic [ADDR_SIZE-1:0] ADDR0,
  input  logic [ADDR_SIZE-1:0] ADDR1,
  input  logic [DATA_SIZE-1:0] WDATA0,
  input  logic [DATA_SIZE-1:0] WDATA1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic                 ACK0,
  output logic                 ACK1,
  output logic [DATA_SIZE-1:0] RDATA,
  output logic [ADDR_SIZE-1:0] RAM_ADDR,
  inout  wire  [DATA_SIZE-1:0] RAM_DATA,
  output logic                 RAM_CS,
  output logic                 RAM_OE,
  output logic                 RAM_WS
);

  state_t                 state_r;
  logic                   last_r;     // port granted most recently
  logic                   owner_r;    // port owning the current transaction
  logic                   we_r;
  logic [DATA_SIZE-1:0]   wdata_r;
  logic                   drive_r;    // block drives RAM_DATA
  logic [1:0]             gnt_s;
  logic                   sel_we_s;
  logic [ADDR_SIZE-1:0]   sel_addr_s;
  logic [DATA_SIZE-1:0]   sel_wdata_s;

  rr_arbiter2 u_rr (
    .req    ({REQ1, REQ0}),
    .last   (last_r),
    .update (state_r == IDLE),
    .gnt    (gnt_s)
  );

  // Mux the winning port's transaction fields
  always_comb begin
    sel_we_s    = WE0;
    sel_addr_s  = ADDR0;
    sel_wdata_s = WDATA0;
    if (gnt_s[1]) begin
      sel_we_s    = WE1;
      sel_addr_s  = ADDR1;
      sel_wdata_s = WDATA1;
    end else begin
      sel_we_s    = WE0;
      sel_addr_s  = ADDR0;
      sel_wdata_s = WDATA0;
    end
  end

  // drive_r and RAM_OE are never set in the same phase, so turnaround is safe
  assign RAM_DATA = drive_r ? wdata_r : {DATA_SIZE{1'bz}};

  // Transaction sequencer with registered pin outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      last_r   <= 1'b1;
      owner_r  <= 1'b0;
      we_r     <= 1'b0;
      wdata_r  <= {DATA_SIZE{1'b0}};
      drive_r  <= 1'b0;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      RDATA    <= {DATA_SIZE{1'b0}};
      RAM_ADDR <= {ADDR_SIZE{1'b0}};
      RAM_CS   <= CS_OFF;
      RAM_OE   <= 1'b0;
      RAM_WS   <= WS_OFF;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_s != 2'b00) begin
            state_r  <= SETUP;
            last_r   <= gnt_s[1];
            owner_r  <= gnt_s[1];
            we_r     <= sel_we_s;
            wdata_r  <= sel_wdata_s;
            drive_r  <= sel_we_s;
            GNT0     <= gnt_s[0];
            GNT1     <= gnt_s[1];
            RAM_ADDR <= sel_addr_s;
            RAM_CS   <= CS_ON;
            RAM_OE   <= ~sel_we_s;
            RAM_WS   <= WS_OFF;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          state_r <= STROBE;
          RAM_WS  <= we_r ? WS_ON : WS_OFF;
        end
        STROBE: begin
          state_r <= DONE;
          RAM_WS  <= WS_OFF;
          RAM_OE  <= 1'b0;
          ACK0    <= ~owner_r;
          ACK1    <= owner_r;
          // RAM is still driving the bus during STROBE of a read
          if (!we_r) begin
            RDATA <= RAM_DATA;
          end else begin
            RDATA <= RDATA;
          end
        end
        DONE: begin
          state_r <= IDLE;
          ACK0    <= 1'b0;
          ACK1    <= 1'b0;
          GNT0    <= 1'b0;
          GNT1    <= 1'b0;
          drive_r <= 1'b0;
          RAM_CS  <= CS_OFF;
          RAM_OE  <= 1'b0;
          RAM_WS  <= WS_OFF;
        end
        default: begin
          state_r <= IDLE;
          ACK0    <= 1'b0;
          ACK1    <= 1'b0;
          GNT0    <= 1'b0;
          GNT1    <= 1'b0;
          drive_r <= 1'b0;
          RAM_CS  <= CS_OFF;
          RAM_OE  <= 1'b0;
          RAM_WS  <= WS_OFF;
        end
      endcase
    end
  end

endmodule
